// File: rtl/dmem_port_sched.sv
// Two-slot data-memory port scheduler: serialises an older/younger request pair onto one SRAM port.
// Define DMEM_ALIGN_CHECK_EN to enable alignment checking at accept time.
module dmem_port_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [3:0]  sel0,
    input  logic [3:0]  sel1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        adel0,
    output logic        ades0,
    output logic        adel1,
    output logic        ades1
);

    typedef enum logic [1:0] {
        IDLE,
        A0,
        A1,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t prev;

    logic        done_q;
    logic        issue1_q;
    logic        we0_q;
    logic        we1_q;
    logic [3:0]  sel0_q;
    logic [3:0]  sel1_q;
    logic [29:0] addr0_q;
    logic [29:0] addr1_q;
    logic [31:0] wdata0_q;
    logic [31:0] wdata1_q;

    logic accept;
    logic mis0;
    logic mis1;
    logic go0;
    logic go1;
    logic unused_lo;

    assign unused_lo = ^{addr0[1:0], addr1[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [3:0] sel,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (sel == 4'b1111)
            bad = (lo != 2'b00);
        else if (sel == 4'b0011 || sel == 4'b1100)
            bad = lo[0];
        return bad;
    endfunction

    assign mis0 = req0 & misaligned(sel0, addr0[1:0]);
    assign mis1 = req1 & misaligned(sel1, addr1[1:0]);
`else
    assign mis0 = 1'b0;
    assign mis1 = 1'b0;
`endif

    // A faulting older slot also kills the younger one.
    assign go0 = req0 & ~mis0;
    assign go1 = req1 & ~mis1 & ~mis0;

    // The done cycle retires the held pair, so it must not be re-accepted.
    assign accept = (state == IDLE) & (req0 | req1) & ~flush & ~done_q;

    assign stall_req = (state == IDLE) ? ((req0 | req1) & ~done_q) : 1'b1;
    assign done      = done_q;

    always_comb begin
        state_nxt       = state;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (go0)
                        state_nxt = A0;
                    else if (go1)
                        state_nxt = A1;
                    else
                        state_nxt = RESP;
                end
            end
            A0: begin
                data_sram_en    = 1'b1;
                data_sram_wen   = we0_q ? sel0_q : 4'b0000;
                data_sram_addr  = {addr0_q, 2'b00};
                data_sram_wdata = wdata0_q;
                state_nxt       = issue1_q ? A1 : RESP;
            end
            A1: begin
                data_sram_en    = 1'b1;
                data_sram_wen   = we1_q ? sel1_q : 4'b0000;
                data_sram_addr  = {addr1_q, 2'b00};
                data_sram_wdata = wdata1_q;
                state_nxt       = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush)
            state_nxt = IDLE;
        if (rst) begin
            data_sram_en  = 1'b0;
            data_sram_wen = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            prev   <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            prev   <= state;
            done_q <= (state == RESP) & ~flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue1_q <= 1'b0;
            we0_q    <= 1'b0;
            we1_q    <= 1'b0;
            sel0_q   <= 4'b0000;
            sel1_q   <= 4'b0000;
            addr0_q  <= 30'h0;
            addr1_q  <= 30'h0;
            wdata0_q <= 32'h0;
            wdata1_q <= 32'h0;
            rdata0   <= 32'h0;
            rdata1   <= 32'h0;
        end else begin
            if (accept) begin
                issue1_q <= go1;
                we0_q    <= we0;
                we1_q    <= we1;
                sel0_q   <= sel0;
                sel1_q   <= sel1;
                addr0_q  <= addr0[31:2];
                addr1_q  <= addr1[31:2];
                wdata0_q <= wdata0;
                wdata1_q <= wdata1;
                rdata0   <= 32'h0;
                rdata1   <= 32'h0;
            end
            // SRAM data arrives one cycle after the access was driven.
            if (state == A1 && prev == A0 && !flush)
                rdata0 <= we0_q ? 32'h0 : data_sram_rdata;
            if (state == RESP && !flush) begin
                if (prev == A1)
                    rdata1 <= we1_q ? 32'h0 : data_sram_rdata;
                else if (prev == A0)
                    rdata0 <= we0_q ? 32'h0 : data_sram_rdata;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            adel0 <= 1'b0;
            ades0 <= 1'b0;
            adel1 <= 1'b0;
            ades1 <= 1'b0;
        end else if (accept) begin
            adel0 <= mis0 & ~we0;
            ades0 <= mis0 & we0;
            adel1 <= mis1 & ~mis0 & ~we1;
            ades1 <= mis1 & ~mis0 & we1;
        end
    end
`else
    assign adel0 = 1'b0;
    assign ades0 = 1'b0;
    assign adel1 = 1'b0;
    assign ades1 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_sched.sv
// Randomised bench for dmem_port_sched against a transaction-level model.
module tb_dmem_port_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, req0, req1, we0, we1;
    logic [3:0]  sel0, sel1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        stall_req, done;
    logic [31:0] rdata0, rdata1;
    logic        adel0, ades0, adel1, ades1;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        tb_wr = 1'b0;
    logic [7:0]  tb_idx = 8'h0;
    logic [31:0] tb_val = 32'h0;

    bit          hold_valid = 0;
    logic [31:0] hold0, hold1;

    dmem_port_sched dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .sel0(sel0), .sel1(sel1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .stall_req(stall_req), .done(done),
        .rdata0(rdata0), .rdata1(rdata1),
        .adel0(adel0), .ades0(ades0), .adel1(adel1), .ades1(ades1)
    );

    // Synchronous-read SRAM with byte enables, plus a preload port.
    always @(posedge clk) begin
        if (tb_wr)
            mem[tb_idx] <= tb_val;
        if (data_sram_en) begin
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i])
                    mem[data_sram_addr[9:2]][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            data_sram_rdata <= mem[data_sram_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit misal(input logic [3:0] s, input logic [1:0] lo);
`ifdef DMEM_ALIGN_CHECK_EN
        if (s == 4'b1111) return lo != 2'b00;
        if (s == 4'b0011 || s == 4'b1100) return lo[0];
`endif
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        sel0 = 0; sel1 = 0; addr0 = 0; addr1 = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic garbage_inputs();
        req0 = 1'($urandom); req1 = 1'($urandom);
        we0 = 1'($urandom); we1 = 1'($urandom);
        sel0 = 4'($urandom); sel1 = 4'($urandom);
        addr0 = $urandom; addr1 = $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        tb_wr = 1; tb_idx = idx; tb_val = val;
        @(negedge clk);
        tb_wr = 0;
        ref_mem[idx] = val;
    endtask

    task automatic idle_cycles(input int m);
        for (int j = 0; j < m; j++) begin
            @(negedge clk);
            idle_inputs(); flush = 0; rst = 0;
            #1;
            chk("idle_en", data_sram_en, 0);
            chk("idle_done", done, 0);
            chk("idle_stall", stall_req, 0);
            if (hold_valid) begin
                chk("hold_rd0", rdata0, hold0);
                chk("hold_rd1", rdata1, hold1);
            end
        end
    endtask

    // abort_k: cycle after accept in which flush (or rst) is raised; 0 = none.
    task automatic run_pair(input bit r0, input bit r1,
                            input bit w0, input bit w1,
                            input logic [3:0] s0, input logic [3:0] s1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input int abort_k, input bit abort_rst);
        bit f0, f1, i0, i1;
        int n, d_cyc, last, slot;
        int slot_of [2];
        bit sw [2];
        logic [3:0] ss [2];
        logic [31:0] sa [2], sd [2], exp_rd [2];
        bit en_exp, after;
        logic [7:0] wi;

        f0 = r0 && misal(s0, a0[1:0]);
        f1 = r1 && misal(s1, a1[1:0]) && !f0;
        i0 = r0 && !f0;
        i1 = r1 && !misal(s1, a1[1:0]) && !f0;
        n = 0;
        if (i0) begin slot_of[n] = 0; n++; end
        if (i1) begin slot_of[n] = 1; n++; end
        d_cyc = n + 2;
        sw[0] = w0; sw[1] = w1; ss[0] = s0; ss[1] = s1;
        sa[0] = a0; sa[1] = a1; sd[0] = d0; sd[1] = d1;
        exp_rd[0] = 0; exp_rd[1] = 0;
        last = (abort_k > 0) ? abort_k + 3 : d_cyc;

        @(negedge clk);
        flush = 0; rst = 0;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        sel0 = s0; sel1 = s1; addr0 = a0; addr1 = a1;
        wdata0 = d0; wdata1 = d1;
        #1;
        chk("c0_done", done, 0);
        chk("c0_stall", stall_req, 1);
        chk("c0_en", data_sram_en, 0);

        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            flush = 0; rst = 0;
            after = (abort_k > 0) && (k > abort_k);
            if (after || k >= d_cyc) idle_inputs();
            else garbage_inputs();
            if (k == abort_k) begin
                if (abort_rst) rst = 1;
                else flush = 1;
            end
            #1;
            en_exp = !after && k <= n && !(k == abort_k && abort_rst);
            chk("en", data_sram_en, en_exp);
            if (en_exp) begin
                slot = slot_of[k-1];
                chk("wen", data_sram_wen, sw[slot] ? ss[slot] : 4'b0);
                chk("addr", data_sram_addr, {sa[slot][31:2], 2'b00});
                chk("wdata", data_sram_wdata, sd[slot]);
                wi = sa[slot][9:2];
                if (sw[slot]) begin
                    for (int b = 0; b < 4; b++)
                        if (ss[slot][b])
                            ref_mem[wi][8*b +: 8] = sd[slot][8*b +: 8];
                end else begin
                    exp_rd[slot] = ref_mem[wi];
                end
            end else begin
                chk("wen_off", data_sram_wen, 0);
            end
            chk("done", done, (abort_k == 0) && (k == d_cyc));
            chk("stall", stall_req, after ? 0 : (k < d_cyc));
            if (abort_k == 0 && k == d_cyc) begin
                chk("rd0", rdata0, exp_rd[0]);
                chk("rd1", rdata1, exp_rd[1]);
                chk("adel0", adel0, f0 && !w0);
                chk("ades0", ades0, f0 && w0);
                chk("adel1", adel1, f1 && !w1);
                chk("ades1", ades1, f1 && w1);
                hold_valid = 1; hold0 = exp_rd[0]; hold1 = exp_rd[1];
            end
            if (abort_rst && k == abort_k + 1) begin
                chk("rst_rd0", rdata0, 0);
                chk("rst_rd1", rdata1, 0);
                chk("rst_flags", {adel0, ades0, adel1, ades1}, 0);
                hold_valid = 1; hold0 = 0; hold1 = 0;
            end
        end
        if (abort_k > 0 && !abort_rst) hold_valid = 0;
    endtask

    function automatic logic [3:0] rand_sel();
        case ($urandom_range(0, 5))
            0, 1: return 4'b1111;
            2: return 4'b0011;
            3: return 4'b1100;
            4: return 4'(1 << $urandom_range(0, 3));
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        bit r0, r1;
        int ak;
        rst = 1; flush = 0; idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_done", done, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_en", data_sram_en, 0);
        chk("rst_rd0", rdata0, 0);
        chk("rst_rd1", rdata1, 0);
        chk("rst_flags", {adel0, ades0, adel1, ades1}, 0);

        for (int i = 0; i < 16; i++) poke(8'(i), $urandom);
        poke(8'h40, 32'hDEADBEEF);
        poke(8'h80, 32'hAABBCCDD);
        poke(8'hC1, 32'h5A5A1234);

        run_pair(1, 0, 0, 0, 4'hF, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("t29_rd0", rdata0, 32'hDEADBEEF);
        idle_cycles(2);

        run_pair(1, 1, 1, 0, 4'b0011, 4'hF, 32'h200, 32'h200,
                 32'h11223344, 32'h0, 0, 0);
        chk("t30_rd1", rdata1, 32'hAABB3344);
        idle_cycles(1);

        run_pair(0, 1, 0, 0, 4'h0, 4'hF, 32'h0, 32'h304, 32'h0, 32'h0, 0, 0);
        chk("t31_rd0", rdata0, 0);
        chk("t31_rd1", rdata1, 32'h5A5A1234);

        run_pair(1, 1, 0, 0, 4'hF, 4'hF, 32'h8, 32'hC, 32'h0, 32'h0, 1, 0);
        run_pair(1, 1, 1, 0, 4'hF, 4'hF, 32'h10, 32'h14, 32'h0BADF00D,
                 32'h0, 2, 1);

        run_pair(1, 1, 0, 1, 4'hF, 4'hF, 32'h102, 32'h4, 32'h0, 32'h77, 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("t33_adel0", adel0, 1);
`else
        chk("t33_adel0", adel0, 0);
`endif
        chk("t33_ades1", ades1, 0);

        // A flush coinciding with a new request must not be accepted.
        @(negedge clk);
        idle_inputs(); req0 = 1; sel0 = 4'hF; addr0 = 32'h20; flush = 1;
        @(negedge clk);
        idle_inputs(); flush = 0;
        #1;
        chk("fl_idle_stall", stall_req, 0);
        chk("fl_idle_en", data_sram_en, 0);
        @(negedge clk);
        #1;
        chk("fl_idle_en2", data_sram_en, 0);
        chk("fl_idle_done", done, 0);
        hold_valid = 0;

        for (int t = 0; t < 250; t++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1;
            ak = 0;
            if ($urandom_range(0, 9) == 0) ak = $urandom_range(1, 2);
            run_pair(r0, r1, 1'($urandom), 1'($urandom), rand_sel(), rand_sel(),
                     {24'h0, 3'($urandom), 3'($urandom), 2'($urandom)},
                     {24'h0, 3'($urandom), 3'($urandom), 2'($urandom)},
                     $urandom, $urandom, ak, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        for (int i = 0; i < 16; i++)
            chk("mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/dmem_port_sched.md
DMEM_PORT_SCHED -- requirements
Module: dmem_port_sched

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: flush  in  1  abandon current pair (exception/branch flush).
REQ-004 SHALL have: req0/req1  in  1 each  slot0/slot1 memory request (slot0 is older).
REQ-005 SHALL have: we0/we1  in  1 each  1=store, 0=load.
REQ-006 SHALL have: sel0/sel1  in  4 each  byte lanes; addr0/addr1  in  32 each; wdata0/wdata1  in  32 each.
REQ-007 SHALL have: data_sram_en  out  1; data_sram_wen  out  4; data_sram_addr  out  32; data_sram_wdata  out  32; data_sram_rdata  in  32.
REQ-008 SHALL have: stall_req  out  1  hold upstream pair; done  out  1  pair complete pulse.
REQ-009 SHALL have: rdata0/rdata1  out  32 each  raw word read per slot; adel0/ades0/adel1/ades1  out  1 each  address-error flags.

Function
REQ-010 SRAM SHALL be single-port, synchronous read: address in cycle k, rdata valid in cycle k+1.
REQ-011 FSM states SHALL be IDLE, A0, A1, RESP; encoding free.
REQ-012 In IDLE with (req0|req1) and !flush, the block SHALL latch both slots' we/sel/addr/wdata and req bits at the clock edge.
REQ-013 Next state from IDLE: A0 if req0 latched, else A1.
REQ-014 A0 SHALL drive slot0 access: en=1, wen=we0?sel0:0, addr={addr0[31:2],2'b00}, wdata=wdata0; next A1 if req1 latched, else RESP.
REQ-015 A1 SHALL drive slot1 access likewise; if previous state was A0, rdata0 SHALL load data_sram_rdata (0 for a store); next RESP.
REQ-016 RESP SHALL drive en=0 and load rdata of the last-issued slot from data_sram_rdata (0 for a store); next IDLE with done=1 for exactly one cycle.
REQ-017 Latency, both slots: accept end of cycle N, accesses N+1/N+2, done in N+4; single slot: done in N+3.
REQ-018 stall_req SHALL be combinational: 1 when (IDLE & (req0|req1) & !done) or state!=IDLE; 0 in the done cycle.
REQ-019 rdata0/rdata1 and exception flags SHALL hold stable from the done cycle until the next accept.
REQ-020 Outside A0/A1, data_sram_en and data_sram_wen SHALL be 0.
REQ-021 flush in any state SHALL force IDLE next cycle, suppress done, and prevent issuing any not-yet-driven access; an access driven in the flush cycle SHALL still complete at the SRAM.
REQ-022 flush and a new request in IDLE simultaneously SHALL not accept.
REQ-023 Request inputs SHALL be ignored while state!=IDLE.

Reset
REQ-024 rst SHALL force state=IDLE; done, stall-relevant state, latched slots, rdata0/rdata1 and all exception flags to 0; rst has priority over flush.
REQ-025 rst mid-pair SHALL abandon the pair with no done pulse; no SRAM access in the reset cycle.

Configuration
REQ-026 Macro DMEM_ALIGN_CHECK_EN SHALL enable alignment checking at accept: sel=1111 needs addr[1:0]=00; sel 0011/1100 needs addr[0]=0.
REQ-027 With DMEM_ALIGN_CHECK_EN: misaligned slot SHALL not be issued, sets adelN (load) or adesN (store); slot0 fault SHALL also suppress slot1; done still pulses (IDLE->RESP when no access remains).
REQ-028 Without DMEM_ALIGN_CHECK_EN: no checking, all slots issued as given, adel*/ades* tied 0.

Verification
REQ-029 req0 load addr 0x100 sel 1111, SRAM word 0xDEADBEEF -> one access cycle N+1, done cycle N+3, rdata0=0xDEADBEEF, stall_req 1 in cycles N..N+2.
REQ-030 req0 store 0x200 wdata 0x11223344 sel 0011 + req1 load 0x200 -> wen=0011 in N+1, read N+2, done N+4, rdata1 shows updated low half 0x3344.
REQ-031 req1 only, load 0x304 -> access in N+1 (A1), done N+3, rdata0=0.
REQ-032 Both slots accepted, flush asserted in A0 cycle -> slot1 never driven, no done, IDLE next cycle, stall_req 0.
REQ-033 DMEM_ALIGN_CHECK_EN defined: req0 load addr 0x102 sel 1111, req1 store -> no SRAM enable, adel0=1, ades1=0, done N+2; undefined: access issued to 0x100, adel0=0.
REQ-034 rst asserted in A1 -> next cycle IDLE, all outputs 0, no done.
